// File: rtl/text_line_ctrl_if.sv
// text_line_ctrl_if: raster, host-write and glyph-ROM signals of text_line_ctrl.
// master = timing gen / host / ROM side, slave = text_line_ctrl.
interface text_line_ctrl_if #(
  parameter int N_CHARS = 16
);
  localparam int AW = $clog2(N_CHARS);

  logic [10:0]   hc;
  logic [10:0]   vc;
  logic          de;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_char;
  logic          commit;
  logic          commit_done;
  logic [7:0]    char_sel;
  logic [2:0]    coor_x;
  logic [2:0]    coor_y;
  logic          glyph_pixel;
  logic          pixel_out;
  logic          de_out;

  modport master (
    output hc, vc, de, wr_en, wr_addr, wr_char, commit, glyph_pixel,
    input  commit_done, char_sel, coor_x, coor_y, pixel_out, de_out
  );

  modport slave (
    input  hc, vc, de, wr_en, wr_addr, wr_char, commit, glyph_pixel,
    output commit_done, char_sel, coor_x, coor_y, pixel_out, de_out
  );
endinterface

// File: rtl/text_line_ctrl.sv
// text_line_ctrl: double-buffered one-line text overlay driving a 5x8 glyph ROM.
// Ports: clk, rst (async, active-high), bus (text_line_ctrl_if.slave).
// Option: TEXT_SCALE2_EN doubles cells to 16x16 (each glyph pixel -> 2x2).
module text_line_ctrl #(
  parameter int N_CHARS = 16,
  parameter int X0      = 64,
  parameter int Y0      = 32
) (
  input  logic             clk,
  input  logic             rst,
  text_line_ctrl_if.slave  bus
);
  localparam int AW = $clog2(N_CHARS);
`ifdef TEXT_SCALE2_EN
  localparam int SH = 4;
`else
  localparam int SH = 3;
`endif
  localparam int RW = N_CHARS << SH;
  localparam int RH = 1 << SH;
  localparam logic [7:0] SPC = 8'h20;

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  state_t     r_state;
  logic       r_done;
  logic [7:0] r_shadow [N_CHARS];
  logic [7:0] r_active [N_CHARS];

  logic          r1_in;
  logic [AW-1:0] r1_cell;
  logic [2:0]    r1_ox;
  logic [2:0]    r1_oy;
  logic          r1_de;

  logic [7:0] r_char;
  logic [2:0] r_cx;
  logic [2:0] r_cy;
  logic       r_blank;
  logic       r2_de;

  logic r_pix;
  logic r_deo;

  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic          w_in;
  logic          w_org;
  logic [AW-1:0] w_cell;
  logic [2:0]    w_ox;
  logic [2:0]    w_oy;
  logic [7:0]    w_code;

  // Offsets wrap when hc/vc < X0/Y0; the >= tests reject those.
  assign w_dx   = bus.hc - 11'(X0);
  assign w_dy   = bus.vc - 11'(Y0);
  assign w_in   = (bus.hc >= 11'(X0)) && (w_dx < 11'(RW)) &&
                  (bus.vc >= 11'(Y0)) && (w_dy < 11'(RH));
  assign w_org  = (bus.hc == 11'd0) && (bus.vc == 11'd0);
  assign w_cell = w_dx[SH +: AW];
  // Dropping the low bit in 2x mode repeats each glyph pixel twice.
  assign w_ox   = w_dx[SH-3 +: 3];
  assign w_oy   = w_dy[SH-3 +: 3];
  assign w_code = r_active[r1_cell];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      for (int i = 0; i < N_CHARS; i++) begin
        r_shadow[i] <= SPC;
        r_active[i] <= SPC;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.commit) r_state <= PEND;
        end
        PEND: begin
          // Copy reads shadow before this edge's host write lands.
          if (w_org) begin
            for (int i = 0; i < N_CHARS; i++)
              r_active[i] <= r_shadow[i];
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= bus.commit ? PEND : IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (bus.wr_en) r_shadow[bus.wr_addr] <= bus.wr_char;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_in   <= 1'b0;
      r1_cell <= '0;
      r1_ox   <= 3'd0;
      r1_oy   <= 3'd0;
      r1_de   <= 1'b0;
      r_char  <= SPC;
      r_cx    <= 3'd0;
      r_cy    <= 3'd0;
      r_blank <= 1'b1;
      r2_de   <= 1'b0;
      r_pix   <= 1'b0;
      r_deo   <= 1'b0;
    end else begin
      r1_in   <= w_in;
      r1_cell <= w_cell;
      r1_ox   <= w_ox;
      r1_oy   <= w_oy;
      r1_de   <= bus.de;
      r_char  <= r1_in ? w_code : SPC;
      r_cx    <= r1_in ? r1_ox : 3'd0;
      r_cy    <= r1_in ? r1_oy : 3'd0;
      // Space must be masked: the ROM draws it as '.'.
      r_blank <= !r1_in || (r1_ox >= 3'd5) || !r1_de ||
                 (w_code == SPC);
      r2_de   <= r1_de;
      r_pix   <= bus.glyph_pixel & ~r_blank;
      r_deo   <= r2_de;
    end
  end

  assign bus.commit_done = r_done;
  assign bus.char_sel    = r_char;
  assign bus.coor_x      = r_cx;
  assign bus.coor_y      = r_cy;
  assign bus.pixel_out   = r_pix;
  assign bus.de_out      = r_deo;
endmodule

// File: tb/tb_text_line_ctrl.sv
// tb_text_line_ctrl: randomized raster/host stimulus vs a behavioural model.
// Small raster (160x40) so nine frames fit comfortably.
module tb_text_line_ctrl;
  localparam int N  = 8;
  localparam int AW = $clog2(N);
  localparam int X0 = 16;
  localparam int Y0 = 4;
  localparam int HT = 160;
  localparam int VT = 40;
`ifdef TEXT_SCALE2_EN
  localparam int SC = 2;
  localparam logic [7:0] CH0 = 8'h37;
`else
  localparam int SC = 1;
  localparam logic [7:0] CH0 = 8'h31;
`endif
  localparam int CW = 8 * SC;

  typedef struct {
    logic [7:0] ch;
    logic [2:0] cx;
    logic [2:0] cy;
    logic       pix;
    logic       de;
    int         hc;
    int         vc;
    int         fr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_line_ctrl_if #(.N_CHARS(N)) bus ();

  text_line_ctrl #(
    .N_CHARS(N),
    .X0(X0),
    .Y0(Y0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Stand-in glyph ROM: fixed rows for '1', '7' and the space dot,
  // lit spacing columns, hashed pixels elsewhere.
  function automatic logic rom(input logic [7:0] c, input int x, input int y);
    int hsh;
    if (x >= 5) return 1'b1;
    if (c == 8'h31 && y == 0) return x == 2;
    if (c == 8'h37 && y == 0) return 1'b1;
    if (c == 8'h20) return (y >= 6) && (x == 2);
    hsh = int'(c) * 37 + x * 11 + y * 5;
    return hsh[2];
  endfunction

  always_comb
    bus.glyph_pixel = rom(bus.char_sel, int'(bus.coor_x), int'(bus.coor_y));

  int   n_chk = 0;
  int   n_fail = 0;
  int   frame = 0;
  int   done_cnt = 0;
  int   ones_cnt = 0;
  bit   rand_wr = 1'b0;
  bit   pend_m = 1'b0;
  bit   done_m = 1'b0;
  logic [7:0] sh_m [N];
  logic [7:0] ac_m [N];
  ent_t q[$];
  int   exp_done [10] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s frame=%0d got=%0h exp=%0h", tag, frame, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh_m[i] = 8'h20;
      ac_m[i] = 8'h20;
    end
    pend_m = 1'b0;
    done_m = 1'b0;
    q.delete();
  endtask

  task automatic drive(input int h, input int v);
    bus.hc = 11'(h);
    bus.vc = 11'(v);
    bus.de = (h < 150) && (v < 36) &&
             ((($urandom % 8) != 0) || (v <= Y0 + 1 && h < X0 + 12));
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    rst = 1'b0;
    if (rand_wr && ($urandom % 40) == 0) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'($urandom_range(N - 1, 4));
      bus.wr_char = (($urandom % 4) == 0) ? 8'h20 : 8'(33 + $urandom % 94);
    end
    case (frame)
      2: begin
        if (v == 1 && h == 10) begin
          bus.wr_en = 1'b1; bus.wr_addr = AW'(0); bus.wr_char = CH0;
        end
        if (v == 1 && h == 11) begin
          bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_char = 8'h32;
        end
        if (v == 30 && h == 5) bus.commit = 1'b1;
      end
      3: begin
        if (v == 20 && h == 10) begin
          bus.wr_en = 1'b1; bus.wr_addr = AW'(0); bus.wr_char = 8'h61;
        end
      end
      4: if (v == 30 && h == 5) bus.commit = 1'b1;
      5: begin
        if (v == 0 && h == 0) begin
          bus.wr_en = 1'b1; bus.wr_addr = AW'(3); bus.wr_char = 8'h5a;
        end
        if (v == 30 && h == 5) bus.commit = 1'b1;
      end
      6: if ((v == 25 || v == 30) && h == 5) bus.commit = 1'b1;
      7: begin
        if (v == 30 && h == 5) bus.commit = 1'b1;
        if (v == 35 && h < 3) rst = 1'b1;
      end
      8: if (v == 30 && h == 5) bus.commit = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_edge(input int h, input int v);
    ent_t e;
    bit   inr;
    done_m = 1'b0;
    if (pend_m && h == 0 && v == 0) begin
      ac_m   = sh_m;
      pend_m = 1'b0;
      done_m = 1'b1;
    end else if (bus.commit) begin
      pend_m = 1'b1;
    end
    if (bus.wr_en) sh_m[bus.wr_addr] = bus.wr_char;
    inr = (h >= X0) && (h < X0 + CW * N) && (v >= Y0) && (v < Y0 + CW);
    if (inr) begin
      e.ch = ac_m[(h - X0) / CW];
      e.cx = 3'(((h - X0) % CW) / SC);
      e.cy = 3'(((v - Y0) % CW) / SC);
    end else begin
      e.ch = 8'h20;
      e.cx = 3'd0;
      e.cy = 3'd0;
    end
    e.pix = (inr && e.cx < 3'd5 && bus.de && e.ch != 8'h20) ?
            rom(e.ch, int'(e.cx), int'(e.cy)) : 1'b0;
    e.de = bus.de;
    e.hc = h;
    e.vc = v;
    e.fr = frame;
    q.push_back(e);
  endtask

  task automatic check_cycle();
    ent_t e;
    if (rst) begin
      chk("rst_char_sel", 32'(bus.char_sel), 32'h20);
      chk("rst_pixel", 32'(bus.pixel_out), 32'd0);
      chk("rst_done", 32'(bus.commit_done), 32'd0);
      chk("rst_de_out", 32'(bus.de_out), 32'd0);
      return;
    end
    chk("commit_done", 32'(bus.commit_done), 32'(done_m));
    if (bus.commit_done) done_cnt++;
    if (bus.pixel_out) ones_cnt++;
    if (q.size() >= 2) begin
      e = q[q.size() - 2];
      chk("char_sel", 32'(bus.char_sel), 32'(e.ch));
      chk("coor_x", 32'(bus.coor_x), 32'(e.cx));
      chk("coor_y", 32'(bus.coor_y), 32'(e.cy));
      if (e.vc == Y0 && e.hc == X0 + 2 && (e.fr == 3 || e.fr == 4))
        chk("slot0_char", 32'(bus.char_sel), 32'(CH0));
      if (e.vc == Y0 && e.hc == X0 + 3 * CW && e.fr == 5)
        chk("slot3_old", 32'(bus.char_sel), 32'h20);
      if (e.vc == Y0 && e.hc == X0 + 3 * CW && e.fr == 6)
        chk("slot3_new", 32'(bus.char_sel), 32'h5a);
    end
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("pixel_out", 32'(bus.pixel_out), 32'(e.pix));
      chk("de_out", 32'(bus.de_out), 32'(e.de));
      if (e.fr == 3) begin
`ifdef TEXT_SCALE2_EN
        if ((e.vc == Y0 || e.vc == Y0 + 1) && e.hc >= X0 && e.hc <= X0 + 9)
          chk("seven_on", 32'(bus.pixel_out), 32'd1);
        if ((e.vc == Y0 || e.vc == Y0 + 1) && e.hc == X0 + 10)
          chk("seven_gap", 32'(bus.pixel_out), 32'd0);
`else
        if (e.vc == Y0 && e.hc == X0 + 2)
          chk("one_top", 32'(bus.pixel_out), 32'd1);
        if (e.vc == Y0 && e.hc == X0 + 5)
          chk("spacing", 32'(bus.pixel_out), 32'd0);
`endif
      end
    end
  endtask

  task automatic run_frame();
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        drive(h, v);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(h, v);
        @(negedge clk);
        check_cycle();
      end
    end
  endtask

  initial begin
    bus.hc = '0;
    bus.vc = '0;
    bus.de = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_char = 8'h20;
    bus.commit = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cycle();
    rst = 1'b0;
    for (int f = 1; f <= 9; f++) begin
      frame = f;
      rand_wr = (f >= 2) && (f <= 6);
      done_cnt = 0;
      ones_cnt = 0;
      run_frame();
      chk("done_count", 32'(done_cnt), 32'(exp_done[f]));
      if (f == 1 || f == 8 || f == 9)
        chk("blank_frame", 32'(ones_cnt), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
